// File: rtl/controlador_copia.sv
// rtl/controlador_copia.sv - ROM-to-RAM block copier with optional RAM readback
module controlador_copia #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int READBACK = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    // k carries one extra bit so DEPTH == 2^ADDR_W never wraps before the
    // equality test against the last index.
    localparam int K_W = ADDR_W + 1;
    localparam logic [K_W-1:0]    K_LAST = K_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CP_RD  = 3'd1;
    localparam logic [2:0] CP_WR  = 3'd2;
    localparam logic [2:0] RB_RD  = 3'd3;
    localparam logic [2:0] RB_OUT = 3'd4;
    localparam logic [2:0] FIM    = 3'd5;

    logic [2:0]     state, state_nxt;
    logic [K_W-1:0] k, k_nxt;
    logic           mode_q, mode_nxt;

    // Next-state logic; abort overrides everything outside IDLE, and in IDLE
    // it blocks a simultaneous start.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        mode_nxt  = mode_q;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            k_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        mode_nxt  = mode;
                        k_nxt     = '0;
                        state_nxt = CP_RD;
                    end
                end
                CP_RD: state_nxt = CP_WR;
                CP_WR: begin
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = (READBACK != 0) ? RB_RD : FIM;
                    end else begin
                        k_nxt     = k + K_W'(1);
                        state_nxt = CP_RD;
                    end
                end
                RB_RD: state_nxt = RB_OUT;
                RB_OUT: begin
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = FIM;
                    end else begin
                        k_nxt     = k + K_W'(1);
                        state_nxt = RB_RD;
                    end
                end
                FIM:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, index and latched copy order; reset forces IDLE immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Moore outputs decoded from state and k; only the data buses pass
    // through the memory read ports combinationally.
    always_comb begin
        rom_addr  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        rd_data   = '0;
        rd_valid  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == FIM);
        case (state)
            CP_RD: rom_addr = k[ADDR_W-1:0];
            CP_WR: begin
                ram_wren  = 1'b1;
                ram_wdata = rom_data;
                ram_addr  = mode_q ? (A_LAST - k[ADDR_W-1:0]) : k[ADDR_W-1:0];
            end
            RB_RD: ram_addr = k[ADDR_W-1:0];
            RB_OUT: begin
                rd_valid = 1'b1;
                rd_data  = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controlador_copia.sv
// tb/tb_controlador_copia.sv - scoreboard bench for controlador_copia
module tb_controlador_copia;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instance A: default parameters
    logic       a_start = 0, a_mode = 0, a_abort = 0;
    logic [4:0] a_rom_addr, a_ram_addr;
    logic [7:0] a_rom_data, a_ram_wdata, a_ram_rdata, a_rd_data;
    logic       a_ram_wren, a_rd_valid, a_busy, a_done;

    controlador_copia dut_a (
        .clock(clock), .reset(reset), .start(a_start), .mode(a_mode), .abort(a_abort),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_wren(a_ram_wren), .ram_rdata(a_ram_rdata),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy), .done(a_done)
    );

    // Instance B: four words, no readback
    logic       b_start = 0, b_mode = 0, b_abort = 0;
    logic [1:0] b_rom_addr, b_ram_addr;
    logic [7:0] b_rom_data, b_ram_wdata, b_rd_data;
    logic [7:0] b_ram_rdata = 8'h00;
    logic       b_ram_wren, b_rd_valid, b_busy, b_done;

    controlador_copia #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .READBACK(0)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .mode(b_mode), .abort(b_abort),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_wren(b_ram_wren), .ram_rdata(b_ram_rdata),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy), .done(b_done)
    );

    // Synchronous ROM/RAM models
    logic [7:0] a_ram [0:31];
    logic       a_clr = 0;
    always @(posedge clock) begin
        a_rom_data <= 8'h10 + {3'b000, a_rom_addr};
        b_rom_data <= 8'hA0 + {6'b000000, b_rom_addr};
        if (a_clr) begin
            for (int i = 0; i < 32; i++) a_ram[i] <= 8'hEE;
        end else begin
            if (a_ram_wren) a_ram[a_ram_addr] <= a_ram_wdata;
            a_ram_rdata <= a_ram[a_ram_addr];
        end
    end

    // Scoreboard
    logic [15:0] a_wr_q[$];
    logic [7:0]  a_rd_q[$];
    logic [15:0] b_wr_q[$];
    logic [15:0] wr_e, bw_e;
    logic [31:0] rd_e;
    int a_done_cnt = 0, b_wr_cnt = 0, b_rd_cnt = 0;

    always @(negedge clock) begin
        if (a_ram_wren) begin
            wr_e = (a_wr_q.size() > 0) ? a_wr_q.pop_front() : 16'hFFFF;
            check("a_wr_addr", {27'd0, a_ram_addr}, {24'd0, wr_e[15:8]});
            check("a_wr_data", {24'd0, a_ram_wdata}, {24'd0, wr_e[7:0]});
        end
        if (a_rd_valid) begin
            rd_e = (a_rd_q.size() > 0) ? {24'd0, a_rd_q.pop_front()} : 32'h100;
            check("a_rd_data", {24'd0, a_rd_data}, rd_e);
        end
        if (a_done) a_done_cnt++;
        if (b_ram_wren) begin
            b_wr_cnt++;
            bw_e = (b_wr_q.size() > 0) ? b_wr_q.pop_front() : 16'hFFFF;
            check("b_wr_addr", {30'd0, b_ram_addr}, {24'd0, bw_e[15:8]});
            check("b_wr_data", {24'd0, b_ram_wdata}, {24'd0, bw_e[7:0]});
        end
        if (b_rd_valid) b_rd_cnt++;
    end

    task automatic clear_ram_a();
        @(negedge clock);
        a_clr = 1;
        @(posedge clock);
        #1 a_clr = 0;
    endtask

    task automatic full_run_a(input logic md);
        int cnt;
        for (int k = 0; k < 32; k++) begin
            a_wr_q.push_back({md ? 8'(31 - k) : 8'(k), 8'(8'h10 + k)});
            a_rd_q.push_back(md ? 8'(8'h2F - k) : 8'(8'h10 + k));
        end
        @(negedge clock);
        a_start = 1;
        a_mode  = md;
        @(posedge clock);
        #1 a_mode = ~md;
        cnt = 0;
        while (cnt < 400) begin
            @(negedge clock);
            cnt++;
            if (cnt == 3) a_start = 0;
            if (a_done) break;
        end
        check("a_done_cycle", cnt, 129);
        @(negedge clock);
        check("a_done_width", {31'd0, a_done}, 0);
        check("a_busy_after", {31'd0, a_busy}, 0);
        check("a_wr_q_empty", a_wr_q.size(), 0);
        check("a_rd_q_empty", a_rd_q.size(), 0);
        for (int k = 0; k < 32; k++)
            check("a_ram_word", {24'd0, a_ram[k]}, md ? 32'(8'h2F - k) : 32'(8'h10 + k));
    endtask

    int cnt, d0;

    initial begin
        #7;
        check("rst_busy", {31'd0, a_busy}, 0);
        check("rst_done", {31'd0, a_done}, 0);
        check("rst_wren", {31'd0, a_ram_wren}, 0);
        check("rst_rd_valid", {31'd0, a_rd_valid}, 0);
        check("rst_rom_addr", {27'd0, a_rom_addr}, 0);
        @(negedge clock);
        reset = 0;

        // Straight and reversed copies with readback
        clear_ram_a();
        full_run_a(1'b0);
        clear_ram_a();
        full_run_a(1'b1);

        // Short copy without readback
        for (int k = 0; k < 4; k++) b_wr_q.push_back({8'(k), 8'(8'hA0 + k)});
        @(negedge clock);
        b_start = 1;
        @(posedge clock);
        #1 b_start = 0;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clock);
            cnt++;
            if (b_done) break;
        end
        check("b_done_cycle", cnt, 9);
        @(negedge clock);
        check("b_wren_pulses", b_wr_cnt, 4);
        check("b_rd_valid_cnt", b_rd_cnt, 0);
        check("b_busy_after", {31'd0, b_busy}, 0);

        // Abort during the write of word 5
        clear_ram_a();
        d0 = a_done_cnt;
        for (int k = 0; k < 6; k++) a_wr_q.push_back({8'(k), 8'(8'h10 + k)});
        @(negedge clock);
        a_start = 1;
        a_mode  = 0;
        @(posedge clock);
        #1 a_start = 0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clock);
            cnt++;
            if (a_ram_wren && a_ram_addr == 5'd5) break;
        end
        check("abort_reach_k5", {31'd0, (cnt < 100)}, 1);
        a_abort = 1;
        @(posedge clock);
        #1 a_abort = 0;
        check("abort_busy", {31'd0, a_busy}, 0);
        check("abort_done", {31'd0, a_done}, 0);
        repeat (8) @(negedge clock);
        check("abort_no_done", a_done_cnt - d0, 0);
        check("abort_wr_q_empty", a_wr_q.size(), 0);
        for (int k = 0; k < 32; k++)
            check("abort_ram_word", {24'd0, a_ram[k]}, (k <= 5) ? 32'(8'h10 + k) : 32'hEE);

        // Reset between edges during readback, start held high throughout
        clear_ram_a();
        d0 = a_done_cnt;
        for (int k = 0; k < 32; k++) begin
            a_wr_q.push_back({8'(k), 8'(8'h10 + k)});
            a_rd_q.push_back(8'(8'h10 + k));
        end
        @(negedge clock);
        a_start = 1;
        a_mode  = 0;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clock);
            cnt++;
            if (a_rd_valid && a_rd_data == 8'h13) break;
        end
        check("rst_reach_rb3", {31'd0, (cnt < 200)}, 1);
        #2 reset = 1;
        #1;
        check("midrst_busy", {31'd0, a_busy}, 0);
        check("midrst_rd_valid", {31'd0, a_rd_valid}, 0);
        check("midrst_wren", {31'd0, a_ram_wren}, 0);
        a_start = 0;
        @(negedge clock);
        reset = 0;
        a_rd_q.delete();
        a_wr_q.delete();
        repeat (5) @(negedge clock);
        check("postrst_idle", {31'd0, a_busy}, 0);
        check("postrst_no_done", a_done_cnt - d0, 0);

        // start and abort together in IDLE
        d0 = a_done_cnt;
        @(negedge clock);
        a_start = 1;
        a_abort = 1;
        @(posedge clock);
        #1;
        check("sa_busy", {31'd0, a_busy}, 0);
        @(negedge clock);
        a_start = 0;
        a_abort = 0;
        repeat (3) @(negedge clock);
        check("sa_still_idle", {31'd0, a_busy}, 0);
        check("sa_no_done", a_done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_copia.md
CONTROLADOR_COPIA -- requirements
Module: controlador_copia

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, the memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 8, the memory data width.
REQ-003 The module SHALL have parameter DEPTH, default 32, the words per transfer; legal range 2..2^ADDR_W.
REQ-004 The module SHALL have parameter READBACK, default 1, which enables the RAM readback phase when 1.
REQ-005 The module SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 The module SHALL have port start  in  1  request a transfer, sampled only in IDLE.
REQ-008 The module SHALL have port mode  in  1  copy order, 0 = straight, 1 = reversed; sampled with start.
REQ-009 The module SHALL have port abort  in  1  cancel the transfer in progress.
REQ-010 The module SHALL have port rom_addr  out  ADDR_W  ROM read address.
REQ-011 The module SHALL have port rom_data  in  DATA_W  ROM read data, valid one cycle after rom_addr.
REQ-012 The module SHALL have port ram_addr  out  ADDR_W  RAM address.
REQ-013 The module SHALL have port ram_wdata  out  DATA_W  RAM write data.
REQ-014 The module SHALL have port ram_wren  out  1  RAM write enable.
REQ-015 The module SHALL have port ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr.
REQ-016 The module SHALL have port rd_data  out  DATA_W  readback word.
REQ-017 The module SHALL have port rd_valid  out  1  marks rd_data valid.
REQ-018 The module SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-019 The module SHALL have port done  out  1  one-cycle pulse on normal completion.

Function
REQ-020 The block SHALL implement states IDLE, CP_RD, CP_WR, RB_RD, RB_OUT and FIM.
REQ-021 The block SHALL, in IDLE with start=1 and abort=0, latch mode, clear index k to 0 and enter CP_RD; start SHALL be ignored in every other state.
REQ-022 The block SHALL, in CP_RD, drive rom_addr=k, then go to CP_WR.
REQ-023 The block SHALL, in CP_WR, assert ram_wren=1 with ram_wdata=rom_data and ram_addr=k (mode 0) or DEPTH-1-k (mode 1).
REQ-024 The block SHALL, leaving CP_WR, go to CP_RD with k+1 if k<DEPTH-1; otherwise clear k and go to RB_RD (READBACK=1) or FIM (READBACK=0).
REQ-025 The block SHALL, in RB_RD, drive ram_addr=k with ram_wren=0, then go to RB_OUT.
REQ-026 The block SHALL, in RB_OUT, drive rd_valid=1 and rd_data=ram_rdata, then go to RB_RD with k+1 if k<DEPTH-1, else to FIM.
REQ-027 The block SHALL hold FIM for exactly one cycle with done=1, then return to IDLE.
REQ-028 The block SHALL hold k in ADDR_W+1 bits and test termination by equality with DEPTH-1, never by a signed or underflow comparison.
REQ-029 The block SHALL deliver the done pulse 4*DEPTH+1 cycles after the start-sampling edge (2*DEPTH+1 when READBACK=0).
REQ-030 The block SHALL, when abort=1 in any non-IDLE state, go to IDLE on the next edge with done=0, leaving already-written RAM words unchanged.
REQ-031 The block SHALL give abort priority over start when both are high in the same cycle.
REQ-032 The block SHALL, in every state not listed above, drive rom_addr=0, ram_addr=0, ram_wdata=0, ram_wren=0, rd_valid=0 and rd_data=0.
REQ-033 The block SHALL derive all outputs from the current state and registers only, as Moore outputs with no input-to-output path except rd_data in RB_OUT and ram_wdata in CP_WR.

Reset
REQ-034 The block SHALL, on reset=1, immediately and asynchronously force state to IDLE and k to 0, with busy=0, done=0, ram_wren=0 and rd_valid=0.
REQ-035 The block SHALL, when reset is asserted mid-transfer, suppress any further RAM write and produce no done pulse.
REQ-036 The block SHALL, after reset is released, require a new start before any activity.

Verification
REQ-037 Bench: defaults, ROM[k]=k+8'h10, mode=0, start pulse -> RAM[k]=k+8'h10 for all k; rd_valid sequence 8'h10..8'h2F; done exactly 129 cycles after start.
REQ-038 Bench: same ROM, mode=1 -> RAM[31-k]=ROM[k]; readback order 8'h2F down to 8'h10.
REQ-039 Bench: READBACK=0, DEPTH=4 -> four ram_wren pulses, never rd_valid, done at cycle 9.
REQ-040 Bench: abort asserted during CP_WR of k=5 -> returns to IDLE next cycle, RAM[0..5] written, RAM[6..] untouched, done=0.
REQ-041 Bench: reset asserted mid-readback, between clock edges -> busy=0 and rd_valid=0 immediately; start held high while busy is ignored.
REQ-042 Bench: start and abort high together in IDLE -> remains IDLE, busy=0.
